// File: rtl/sync_edge_multi.sv
// Multi-channel async-input synchroniser with per-channel edge/filter mode.
// Ports: clk, rst_n (sync, active-low), async_in, sticky_clr -> level_out, pulse_out, sticky_out, ovf_out.
module sync_edge_multi #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic [2*WIDTH-1:0] MODE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  input  logic [WIDTH-1:0] sticky_clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] sticky_out,
  output logic [WIDTH-1:0] ovf_out
);

  localparam logic [1:0] M_RISE = 2'd0;
  localparam logic [1:0] M_FALL = 2'd1;
  localparam logic [1:0] M_TOG  = 2'd2;
  localparam logic [1:0] M_FILT = 2'd3;

  localparam int unsigned CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_edge_multi: STAGES must be 2..4");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
    $error("sync_edge_multi: FILT_CYCLES must be 1..255");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] ev;

  always_comb begin
    logic [1:0] mode;
    sync_d[0] = async_in;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    s        = sync_q[STAGES-1];
    filt_d   = filt_q;
    src      = '0;
    ev       = '0;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    mode     = M_RISE;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      mode = MODE[2*i +: 2];
      if (mode == M_FILT) begin
        // any agreeing sample restarts the run of disagreeing samples
        if (s[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = s[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
        src[i] = filt_q[i];
      end else begin
        filt_d[i] = 1'b0;
        cnt_d[i]  = '0;
        src[i]    = s[i];
      end
      unique case (mode)
        M_RISE: ev[i] = src[i] & ~prev_q[i];
        M_FALL: ev[i] = ~src[i] & prev_q[i];
        M_TOG:  ev[i] = src[i] ^ prev_q[i];
        M_FILT: ev[i] = src[i] ^ prev_q[i];
      endcase
      // an event wins over a same-cycle clear
      if (ev[i]) begin
        sticky_d[i] = 1'b1;
      end else if (sticky_clr[i]) begin
        sticky_d[i] = 1'b0;
      end
      if (ev[i] && sticky_q[i] && !sticky_clr[i]) begin
        ovf_d[i] = 1'b1;
      end else if (sticky_clr[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
    prev_d  = src;
    pulse_d = ev;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q   <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      ovf_q    <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign level_out  = src;
  assign pulse_out  = pulse_q;
  assign sticky_out = sticky_q;
  assign ovf_out    = ovf_q;

endmodule
